sd_nibble_packer: RTL and testbench

- Sits directly downstream of SD_read and upstream of DataInPro.
- Takes the 4-bit data stream (mydata_o / myvalid_o) for each SD block and packs nibble pairs into bytes, high nibble first.
- Buffers the bytes in a small FIFO with a valid/ready output, so the consumer can stall for a few cycles without data loss.
- Checks block framing (byte count, odd nibble) and reports block completion, block errors and overflow.

---
 rtl/sd_pkg.sv | 6 +
 rtl/sd_sync_fifo.sv | 41 ++++
 rtl/sd_nibble_packer.sv | 71 +++++++
 tb/tb_sd_nibble_packer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: shared constants and FSM encoding for the SD nibble packer
package sd_pkg;
    localparam int SD_BLK_BYTES = 512;
    localparam int SD_NIB_W     = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, CLOSE = 2'd2} sd_state_t;
endpackage

// File: rtl/sd_sync_fifo.sv
// sd_sync_fifo: first-word fall-through FIFO; a pop frees a slot for a same-cycle push when full
module sd_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    always_comb begin
        empty   = count == '0;
        full    = count == (AW+1)'(DEPTH);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = empty ? '0 : mem[rd_ptr];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/sd_nibble_packer.sv
// sd_nibble_packer: packs SD_read nibbles into bytes, buffers them and checks block framing
module sd_nibble_packer
    import sd_pkg::*;
#(
    parameter int BLK_BYTES  = SD_BLK_BYTES,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 10
) (
    input  logic                SD_clk,
    input  logic                rst,
    input  logic [SD_NIB_W-1:0] nib_i,
    input  logic                nib_valid_i,
    input  logic                data_busy_i,
    output logic [7:0]          byte_o,
    output logic                byte_valid_o,
    input  logic                byte_ready_i,
    output logic                blk_done_o,
    output logic                blk_err_o,
    output logic                ovf_o,
    output logic [31:0]         blk_cnt_o
);
    sd_state_t state, state_nx;
    logic busy_q, rise, fall, accept, push, full, empty, phase;
    logic [SD_NIB_W-1:0] hi;
    logic [CNT_W-1:0] cnt;
    // CLOSE also honours a rise so a one-cycle busy gap between blocks is not missed
    always_comb begin
        rise         = data_busy_i && !busy_q;
        fall         = !data_busy_i && busy_q;
        accept       = state == RECV && nib_valid_i;
        push         = accept && phase;
        state_nx     = state == RECV ? (fall ? CLOSE : RECV) : (rise ? RECV : IDLE);
        blk_done_o   = state == CLOSE;
        blk_err_o    = blk_done_o && (cnt != CNT_W'(BLK_BYTES) || phase);
        byte_valid_o = !empty;
    end
    always_ff @(posedge SD_clk) begin
        if (rst) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            phase     <= 1'b0;
            hi        <= '0;
            cnt       <= '0;
            ovf_o     <= 1'b0;
            blk_cnt_o <= '0;
        end else begin
            state  <= state_nx;
            busy_q <= data_busy_i;
            if (state != RECV && state_nx == RECV) begin
                cnt   <= '0;
                phase <= 1'b0;
            end else if (accept) begin
                phase <= !phase;
                if (!phase) hi <= nib_i;
                else if (cnt != '1) cnt <= cnt + 1'b1;
            end
            if (push && full && !byte_ready_i) ovf_o <= 1'b1;
            if (blk_done_o) blk_cnt_o <= blk_cnt_o + 32'd1;
        end
    end
    sd_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (SD_clk),
        .rst   (rst),
        .push  (push),
        .din   ({hi, nib_i}),
        .pop   (byte_ready_i),
        .dout  (byte_o),
        .empty (empty),
        .full  (full)
    );
endmodule

// File: tb/tb_sd_nibble_packer.sv
// tb_sd_nibble_packer: directed and random blocks checked against a queue-based packing model
module tb_sd_nibble_packer;
    logic SD_clk = 1'b0, rst = 1'b1;
    logic [3:0] nib_i = '0;
    logic nib_valid_i = 1'b0, data_busy_i = 1'b0, byte_ready_i = 1'b0;
    logic [7:0] byte_o;
    logic byte_valid_o, blk_done_o, blk_err_o, ovf_o;
    logic [31:0] blk_cnt_o;
    always #5 SD_clk = ~SD_clk;
    sd_nibble_packer dut (
        .SD_clk       (SD_clk),
        .rst          (rst),
        .nib_i        (nib_i),
        .nib_valid_i  (nib_valid_i),
        .data_busy_i  (data_busy_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .blk_done_o   (blk_done_o),
        .blk_err_o    (blk_err_o),
        .ovf_o        (ovf_o),
        .blk_cnt_o    (blk_cnt_o)
    );
    int checks = 0, errors = 0, n_done = 0, n_err = 0, rmode = 0;
    logic [7:0] mq[$], got[$];
    bit m_open, m_phase, m_prev, m_ovf, exp_done, exp_err;
    logic [3:0] m_hi;
    int m_bytes;
    logic [31:0] m_blkcnt;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // one clock: drive inputs, advance the model at the edge, compare just after it
    task automatic step(input logic nv, input logic [3:0] nb, input logic bz, input logic rd);
        nib_valid_i = nv;
        nib_i = nb;
        data_busy_i = bz;
        byte_ready_i = rd;
        @(posedge SD_clk);
        if (rst) begin
            mq.delete();
            {m_open, m_phase, m_prev, m_ovf, exp_done, exp_err} = '0;
            m_hi = '0;
            m_bytes = 0;
            m_blkcnt = '0;
        end else begin
            if (rd && mq.size() > 0) got.push_back(mq.pop_front());
            if (exp_done) m_blkcnt++;
            exp_done = 0;
            if (m_open && nv) begin
                if (!m_phase) begin
                    m_hi = nb;
                    m_phase = 1;
                end else begin
                    m_phase = 0;
                    m_bytes++;
                    if (mq.size() < 16) mq.push_back({m_hi, nb});
                    else m_ovf = 1;
                end
            end
            if (m_open && !bz && m_prev) begin
                m_open = 0;
                exp_done = 1;
                exp_err = (m_bytes != 512) || m_phase;
            end else if (!m_open && bz && !m_prev) begin
                m_open = 1;
                m_bytes = 0;
                m_phase = 0;
            end
            m_prev = bz;
        end
        #1;
        chk("valid", byte_valid_o, mq.size() != 0);
        if (mq.size() > 0) chk("byte", byte_o, mq[0]);
        chk("done", blk_done_o, exp_done);
        chk("err", blk_err_o, exp_done && exp_err);
        chk("ovf", ovf_o, m_ovf);
        chk("blkcnt", blk_cnt_o, m_blkcnt);
        if (blk_done_o) n_done++;
        if (blk_done_o && blk_err_o) n_err++;
    endtask
    // n nibbles; ready held low for nibble indices [s0,s1); optionally last nibble on the falling cycle
    task automatic blk(input int n, input bit pat, input bit fall_last, input int s0, input int s1);
        logic [3:0] nb;
        logic rd;
        step(0, 0, 1, 1);
        for (int i = 0; i < n; i++) begin
            nb = pat ? 4'(i) : 4'($urandom);
            rd = (i >= s0 && i < s1) ? 1'b0 : (rmode != 0 ? ($urandom_range(0, 3) != 0) : 1'b1);
            step(1, nb, !(fall_last && i == n - 1), rd);
        end
        if (!fall_last) step(0, 0, 0, 1);
    endtask
    task automatic drain(input int k);
        repeat (k) step(0, 0, 0, 1);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        got.delete();
        n_done = 0;
        n_err = 0;
    endtask
    initial begin
        int bad;
        do_reset();
        chk("rst_byte_o", byte_o, 0);
        chk("rst_valid", byte_valid_o, 0);
        chk("rst_done", blk_done_o, 0);
        chk("rst_err", blk_err_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_blkcnt", blk_cnt_o, 0);
        blk(1024, 1, 1, 0, 0);
        drain(20);
        bad = 0;
        foreach (got[i]) if (got[i] !== {4'(2 * i), 4'(2 * i + 1)}) bad++;
        chk("nom_count", got.size(), 512);
        chk("nom_bytes", bad, 0);
        chk("nom_done", n_done, 1);
        chk("nom_err", n_err, 0);
        chk("nom_blkcnt", blk_cnt_o, 1);
        do_reset();
        blk(1024, 0, 0, 0, 33);
        drain(40);
        chk("full_pushpop_ovf", ovf_o, 0);
        chk("full_pushpop_count", got.size(), 512);
        do_reset();
        blk(1024, 0, 0, 100, 140);
        drain(40);
        chk("stall_ovf", ovf_o, 1);
        chk("stall_count", got.size(), 507);
        chk("stall_err", n_err, 0);
        do_reset();
        blk(1023, 0, 0, 0, 0);
        drain(20);
        chk("short_count", got.size(), 511);
        chk("short_done", n_done, 1);
        chk("short_err", n_err, 1);
        chk("short_blkcnt", blk_cnt_o, 1);
        step(0, 0, 1, 1);
        for (int i = 0; i < 300; i++) step(1, 4'($urandom), 1, 1'($urandom));
        rst = 1'b1;
        step(0, 0, 0, 1);
        rst = 1'b0;
        chk("midrst_valid", byte_valid_o, 0);
        chk("midrst_byte_o", byte_o, 0);
        chk("midrst_ovf", ovf_o, 0);
        chk("midrst_blkcnt", blk_cnt_o, 0);
        chk("midrst_done", blk_done_o, 0);
        got.delete();
        n_done = 0;
        blk(1024, 1, 1, 0, 0);
        drain(20);
        chk("midrst_count", got.size(), 512);
        chk("midrst_blkcnt_after", blk_cnt_o, 1);
        do_reset();
        blk(1024, 0, 0, 0, 0);
        blk(1024, 0, 0, 0, 0);
        drain(20);
        chk("b2b_done", n_done, 2);
        chk("b2b_err", n_err, 0);
        chk("b2b_blkcnt", blk_cnt_o, 2);
        chk("b2b_count", got.size(), 1024);
        rmode = 1;
        blk(1024, 0, 1, 0, 0);
        blk(1000, 0, 0, 0, 0);
        rmode = 0;
        drain(60);
        chk("rand_done", n_done, 4);
        chk("rand_blkcnt", blk_cnt_o, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
